// File: rtl/word_uart_tx.sv
// word_uart_tx: holds one 32-bit (or single-byte) word and serialises it
// MSB byte first as back-to-back 8N1 UART frames on TXD.
module word_uart_tx #(
    parameter int BAUD_DIV = 868
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  MODE,
    input  logic [31:0] DIN,
    input  logic        WE,
    output logic        READY,
    output logic        TXD,
    output logic        BUSY,
    output logic        OVF
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_t;

    txState_t        r_state;
    txState_t        w_nextState;
    logic [BW-1:0]   r_baudCnt;
    logic [BW-1:0]   w_nextBaud;
    logic [2:0]      r_bitIdx;
    logic [2:0]      w_nextBit;
    logic            r_txd;
    logic            w_nextTxd;
    logic [7:0]      r_txByte;

    logic [31:0]     r_holdData;
    logic [2:0]      r_holdCnt;
    logic            r_holdValid;
    logic            r_ready;
    logic            r_ovf;

    logic            w_baudEnd;
    logic            w_take;
    logic            w_accept;
    logic            w_unusedMode;

    // MODE[1] carries no meaning for this block.
    assign w_unusedMode = MODE[1];

    assign w_baudEnd = (r_baudCnt == BAUD_LAST);
    // A byte leaves the holding register in the first cycle of its start bit.
    assign w_take    = (r_state == START) && (r_baudCnt == '0);
    assign w_accept  = WE && r_ready;

    assign READY = r_ready;
    assign TXD   = r_txd;
    assign OVF   = r_ovf;
    assign BUSY  = r_holdValid | (r_state != IDLE);

    // Holding register: accept new words, hand bytes to the FSM, flag overflow.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_holdData  <= '0;
            r_holdCnt   <= '0;
            r_holdValid <= 1'b0;
            r_ready     <= 1'b1;
            r_ovf       <= 1'b0;
            r_txByte    <= '0;
        end else begin
            if (w_take) begin
                r_txByte   <= r_holdData[31:24];
                r_holdData <= {r_holdData[23:0], 8'h00};
                r_holdCnt  <= r_holdCnt - 3'd1;
                if (r_holdCnt == 3'd1) begin
                    r_holdValid <= 1'b0;
                    r_ready     <= 1'b1;
                end
            end
            if (w_accept) begin
                r_holdValid <= 1'b1;
                r_ready     <= 1'b0;
                if (MODE[0]) begin
                    r_holdData <= {DIN[7:0], 24'h000000};
                    r_holdCnt  <= 3'd1;
                end else begin
                    r_holdData <= DIN;
                    r_holdCnt  <= 3'd4;
                end
            end
            if (WE && !r_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // TX FSM state, baud/bit counters and the registered serial output.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_nextState;
            r_baudCnt <= w_nextBaud;
            r_bitIdx  <= w_nextBit;
            r_txd     <= w_nextTxd;
        end
    end

    // Next-state, counter and line-level decode for the frame sequencer.
    always_comb begin
        w_nextState = r_state;
        w_nextBit   = r_bitIdx;
        w_nextBaud  = '0;
        w_nextTxd   = 1'b1;

        case (r_state)
            IDLE: begin
                if (r_holdValid) begin
                    w_nextState = START;
                end
            end
            START: begin
                if (w_baudEnd) begin
                    w_nextState = DATA;
                    w_nextBit   = 3'd0;
                end
            end
            DATA: begin
                if (w_baudEnd) begin
                    if (r_bitIdx == 3'd7) begin
                        w_nextState = STOP;
                        w_nextBit   = 3'd0;
                    end else begin
                        w_nextBit = r_bitIdx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (w_baudEnd) begin
                    w_nextState = r_holdValid ? START : IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        if (w_nextState != r_state) begin
            w_nextBaud = '0;
        end else if (w_baudEnd) begin
            w_nextBaud = '0;
        end else begin
            w_nextBaud = r_baudCnt + BW'(1);
        end

        case (w_nextState)
            IDLE:    w_nextTxd = 1'b1;
            START:   w_nextTxd = 1'b0;
            DATA:    w_nextTxd = r_txByte[w_nextBit];
            STOP:    w_nextTxd = 1'b1;
            default: w_nextTxd = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_word_uart_tx.sv
// tb_word_uart_tx: directed checks of word_uart_tx framing, timing and overflow.
module tb_word_uart_tx;

    localparam int B = 4;

    logic        CLK;
    logic        RST;
    logic [1:0]  MODE;
    logic [31:0] DIN;
    logic        WE;
    logic        READY;
    logic        TXD;
    logic        BUSY;
    logic        OVF;

    int cyc;
    int checks;
    int errors;
    int readyRise;
    int ovfRise;
    int t;
    logic lastBusy;

    word_uart_tx #(.BAUD_DIV(B)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .MODE  (MODE),
        .DIN   (DIN),
        .WE    (WE),
        .READY (READY),
        .TXD   (TXD),
        .BUSY  (BUSY),
        .OVF   (OVF)
    );

    // 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic [31:0] din, output int tAcc);
        tAcc = cyc;
        MODE = mode;
        DIN  = din;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    task automatic checkFrames(input logic [31:0] word, input int n, input string tag,
                               input int we1At, input logic [31:0] we1Din,
                               input int we2At, input logic [31:0] we2Din);
        logic [7:0] cur;
        logic [9:0] got;
        logic       expBit;
        int         bad;
        readyRise = -1;
        ovfRise   = -1;
        for (int i = 0; i < n; i++) begin
            cur = word[31-8*i -: 8];
            got = '0;
            bad = 0;
            for (int k = 0; k < 10; k++) begin
                for (int j = 0; j < B; j++) begin
                    if (k == 0)      expBit = 1'b0;
                    else if (k == 9) expBit = 1'b1;
                    else             expBit = cur[k-1];
                    if (TXD !== expBit) bad++;
                    if (j == B/2) got[k] = TXD;
                    if (READY === 1'b1 && readyRise < 0) readyRise = cyc;
                    if (OVF === 1'b1 && ovfRise < 0) ovfRise = cyc;
                    lastBusy = BUSY;
                    if (cyc == we1At) begin
                        DIN = we1Din;
                        WE  = 1'b1;
                    end else if (cyc == we2At) begin
                        DIN = we2Din;
                        WE  = 1'b1;
                    end else begin
                        WE  = 1'b0;
                    end
                    tick();
                end
            end
            WE = 1'b0;
            checkOutput($sformatf("%s byte%0d frame", tag, i), {22'd0, got}, {22'd0, 1'b1, cur, 1'b0});
            checkOutput($sformatf("%s byte%0d badCycles", tag, i), bad, 0);
        end
    endtask

    task automatic checkIdle(input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (TXD !== 1'b1 || BUSY !== 1'b0 || READY !== 1'b1) bad++;
            tick();
        end
        checkOutput(tag, bad, 0);
    endtask

    // Directed scenario sequence.
    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        RST    = 1'b1;
        WE     = 1'b0;
        MODE   = 2'b00;
        DIN    = '0;
        lastBusy = 1'b0;

        tick();
        tick();
        RST = 1'b0;
        checkOutput("resetReady", READY, 1);
        checkOutput("resetTxd", TXD, 1);
        checkOutput("resetBusy", BUSY, 0);
        checkOutput("resetOvf", OVF, 0);
        checkIdle(50, "resetIdle");
        checkOutput("resetOvfIdle", OVF, 0);

        // Single 4-byte word.
        applyStimulus(2'b00, 32'h12345678, t);
        checkOutput("wordReadyLow", READY, 0);
        checkOutput("wordBusyHigh", BUSY, 1);
        checkOutput("wordTxdIdle", TXD, 1);
        tick();
        checkFrames(32'h12345678, 4, "word", -1, 0, -1, 0);
        checkOutput("wordReadyRise", readyRise - t, 123);
        checkOutput("wordBusyLast", lastBusy, 1);
        checkOutput("wordBusyFall", BUSY, 0);
        checkIdle(10, "wordIdle");

        // Byte mode.
        applyStimulus(2'b01, 32'hFFFFFFA5, t);
        tick();
        checkFrames(32'hA5000000, 1, "byteMode", -1, 0, -1, 0);
        checkOutput("byteReadyRise", readyRise - t, 3);
        checkIdle(20, "byteIdle");

        // Overflow; MODE flips after accept and must not matter.
        checkOutput("ovfPre", OVF, 0);
        applyStimulus(2'b00, 32'hDEADBEEF, t);
        MODE = 2'b01;
        tick();
        checkFrames(32'hDEADBEEF, 4, "ovf", t + 5, 32'h01020304, -1, 0);
        checkOutput("ovfRise", ovfRise - t, 6);
        checkIdle(20, "ovfIdle");
        checkOutput("ovfSticky", OVF, 1);

        // Back-to-back single bytes.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("ovfCleared", OVF, 0);
        applyStimulus(2'b01, 32'h00000011, t);
        tick();
        checkFrames(32'h11220000, 2, "b2b", t + 3, 32'h00000022, t + 42, 32'h00000033);
        checkOutput("b2bOvfRise", ovfRise - t, 43);
        checkIdle(20, "b2bIdle");

        // Reset in the middle of the second byte.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        applyStimulus(2'b00, 32'hA5A5A5A5, t);
        tick();
        checkFrames(32'hA5A5A5A5, 1, "rstFirst", -1, 0, -1, 0);
        while (cyc < t + 50) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("rstTxd", TXD, 1);
        checkOutput("rstReady", READY, 1);
        checkOutput("rstBusy", BUSY, 0);
        checkIdle(60, "rstIdle");
        applyStimulus(2'b01, 32'h000000C3, t);
        tick();
        checkFrames(32'hC3000000, 1, "afterRst", -1, 0, -1, 0);
        checkOutput("afterRstReadyRise", readyRise - t, 3);
        checkIdle(10, "afterRstIdle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
